afifo_rd_stream: RTL and testbench

- Read-side consumer stage that sits directly downstream of the asynchronous FIFO, in the rdclk domain.
- Drives the FIFO pop interface and captures popped words, accounting for the FIFO's one-cycle read latency.
- Delivers the words on a valid/ready stream toward the checker/sink through a 2-entry skid buffer.
- Adds frame marking (m_last) and a delivered-word counter.

---
 rtl/afifo_rd_stream_if.sv | 23 ++
 rtl/afifo_rd_stream.sv | 109 ++++++++++
 tb/tb_afifo_rd_stream.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_rd_stream_if.sv
// Pop-side and stream-side signals of the read-domain consumer stage.
// Handshake: a word moves on a rising edge where m_valid && m_ready; m_data/m_last are held while stalled.
interface afifo_rd_stream_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] fifo_data_out;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    input  fifo_data_out, fifo_empty, m_ready,
    output fifo_pop, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_data_out, fifo_empty, m_ready,
    input  fifo_pop, m_data, m_valid, m_last
  );
endinterface

// File: rtl/afifo_rd_stream.sv
// Pops the async FIFO (one-cycle read latency), buffers words in a 2-entry skid
// buffer and streams them out with frame marking and a delivered-word counter.
module afifo_rd_stream #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic             rdclk,
  input  logic             rd_rst,
  input  logic             en,
  afifo_rd_stream_if.master bus,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic [1:0]       dbg_state
);
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] e0_q, e0_d;
  logic [DATA_W-1:0] e1_q, e1_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       cap;
  logic       deq;
  logic       valid;
  logic       pop;
  logic [2:0] level;

  always_comb begin
    cap   = inflight_q;
    valid = (state_q != EMPTY);
    deq   = valid && bus.m_ready;
    // Occupancy after this edge, counting the word already in flight.
    level = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, deq};
    pop   = rd_rst && en && !bus.fifo_empty && (level < 3'd2);

    inflight_d = pop;
    state_d    = state_q;
    e0_d       = e0_q;
    e1_d       = e1_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;

    case (state_q)
      EMPTY: begin
        if (cap) begin
          state_d = ONE;
          e0_d    = bus.fifo_data_out;
        end
      end
      ONE: begin
        case ({cap, deq})
          2'b10: begin
            state_d = TWO;
            e1_d    = bus.fifo_data_out;
          end
          2'b11:   e0_d    = bus.fifo_data_out;
          2'b01:   state_d = EMPTY;
          default: state_d = ONE;
        endcase
      end
      TWO: begin
        // The pop rule keeps cap without deq from ever arriving here.
        if (deq) begin
          e0_d = e1_q;
          if (cap) e1_d    = bus.fifo_data_out;
          else     state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (deq) begin
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge rdclk or negedge rd_rst) begin
    if (!rd_rst) begin
      state_q    <= EMPTY;
      inflight_q <= 1'b0;
      e0_q       <= '0;
      e1_q       <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.fifo_pop = pop;
  assign bus.m_valid  = valid;
  assign bus.m_data   = e0_q;
  assign bus.m_last   = valid && (idx_q == LAST_IDX);
  assign word_cnt     = cnt_q;
  assign busy         = inflight_q || valid;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_afifo_rd_stream.sv
// Bench for afifo_rd_stream: FIFO model with one-cycle read latency, a
// per-cycle vector table for streaming, and directed multi-cycle corner sequences.
module tb_afifo_rd_stream;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  logic             rdclk = 1'b0;
  logic             rd_rst = 1'b0;
  logic             en = 1'b0;
  logic [CNT_W-1:0] word_cnt;
  logic             busy;
  logic [1:0]       dbg_state;

  afifo_rd_stream_if #(.DATA_W(DATA_W)) bus ();

  afifo_rd_stream #(.DATA_W(DATA_W), .FRAME_LEN(4), .CNT_W(CNT_W)) dut (
    .rdclk     (rdclk),
    .rd_rst    (rd_rst),
    .en        (en),
    .bus       (bus),
    .word_cnt  (word_cnt),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  always #5 rdclk = ~rdclk;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- FIFO model ----------------
  logic [7:0] mem [0:15];
  int         rd_ptr = 0;
  int         wr_ptr = 0;
  int         pops_total = 0;
  logic       fifo_clr = 1'b1;
  logic       gap = 1'b0;
  logic [DATA_W-1:0] exp_q[$];

  assign bus.fifo_empty = gap || (rd_ptr >= wr_ptr);

  always @(posedge rdclk) begin
    if (fifo_clr) begin
      rd_ptr     <= 0;
      pops_total <= 0;
    end else if (bus.fifo_pop) begin
      bus.fifo_data_out <= mem[rd_ptr[3:0]];
      rd_ptr            <= rd_ptr + 1;
      pops_total        <= pops_total + 1;
      exp_q.push_back(mem[rd_ptr[3:0]]);
    end
  end

  // ---------------- scoreboard / monitor ----------------
  int         exp_rd = 0;
  int         tb_idx = 0;
  logic [8:0] got_q[$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = '0;
  logic       stall_last = 1'b0;

  always @(negedge rdclk) begin
    if (!rd_rst) begin
      exp_rd  = exp_q.size();
      tb_idx  = 0;
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", 32'(bus.m_valid), 32'd1);
        chk("hold_data", 32'(bus.m_data), 32'(stall_data));
        chk("hold_last", 32'(bus.m_last), 32'(stall_last));
      end
      chk("no_cap_in_two",
          32'(dbg_state == 2'd2 && dut.inflight_q && !(bus.m_valid && bus.m_ready)), 32'd0);
      if (bus.m_valid && bus.m_ready) begin
        if (exp_rd < exp_q.size()) chk("sb_data", 32'(bus.m_data), 32'(exp_q[exp_rd]));
        else chk("sb_underflow", 32'd1, 32'd0);
        exp_rd++;
        chk("sb_last", 32'(bus.m_last), 32'(tb_idx == 3));
        tb_idx = (tb_idx == 3) ? 0 : tb_idx + 1;
        got_q.push_back({bus.m_last, bus.m_data});
      end
      stall_q    = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
      stall_last = bus.m_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge rdclk);
    #1;
  endtask

  // Reset with a fresh 8-word FIFO, check reset outputs, release at the start of cycle c0.
  task automatic start_test(input logic [7:0] base, input logic rdy);
    rd_rst = 1'b0;
    en = 1'b1;
    gap = 1'b0;
    bus.m_ready = rdy;
    fifo_clr = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = base + 8'(i);
    wr_ptr = 8;
    next_cycle();
    next_cycle();
    fifo_clr = 1'b0;
    @(negedge rdclk);
    chk("rst_pop", 32'(bus.fifo_pop), 32'd0);
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_last", 32'(bus.m_last), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    chk("rst_data", 32'(bus.m_data), 32'd0);
    next_cycle();
    rd_rst = 1'b1;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (!(busy == 1'b0 && (bus.fifo_empty || !en)) && n < max) begin
      next_cycle();
      n++;
    end
    chk("drain_timeout", 32'(n >= max), 32'd0);
    next_cycle();
  endtask

  task automatic check_got(input int base, input logic [7:0] first, input int n);
    chk("got_count", 32'(got_q.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < got_q.size(); i++) begin
      chk("got_data", 32'(got_q[base+i][7:0]), 32'(first + 8'(i)));
      chk("got_last", 32'(got_q[base+i][8]), 32'((i % 4) == 3));
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        pop;
    logic        vld;
    logic [7:0]  dat;
    logic        last;
    logic        bsy;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [0:10];
  int   gb;

  initial begin
    // Free-running stream, cycle by cycle from the release of reset.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1, 16'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 16'd1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 16'd2};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 1'b1, 16'd3};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h14, 1'b0, 1'b1, 16'd4};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 1'b1, 16'd5};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h16, 1'b0, 1'b1, 16'd6};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h17, 1'b1, 1'b1, 16'd7};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 16'd8};

    bus.m_ready = 1'b1;

    // Streaming
    start_test(8'h10, 1'b1);
    gb = got_q.size();
    for (int c = 0; c < 11; c++) begin
      bus.m_ready = vecs[c].rdy;
      @(negedge rdclk);
      chk("tbl_pop", 32'(bus.fifo_pop), 32'(vecs[c].pop));
      chk("tbl_valid", 32'(bus.m_valid), 32'(vecs[c].vld));
      if (vecs[c].vld) begin
        chk("tbl_data", 32'(bus.m_data), 32'(vecs[c].dat));
        chk("tbl_last", 32'(bus.m_last), 32'(vecs[c].last));
      end
      chk("tbl_busy", 32'(busy), 32'(vecs[c].bsy));
      chk("tbl_cnt", 32'(word_cnt), 32'(vecs[c].cnt));
      next_cycle();
    end
    check_got(gb, 8'h10, 8);

    // Backpressure: two pops fill the skid buffer, then the head holds.
    start_test(8'h10, 1'b0);
    gb = got_q.size();
    for (int k = 0; k < 6; k++) begin
      @(negedge rdclk);
      if (k >= 2) chk("bp_pop", 32'(bus.fifo_pop), 32'd0);
      next_cycle();
    end
    chk("bp_pops", 32'(pops_total), 32'd2);
    chk("bp_state", 32'(dbg_state), 32'd2);
    chk("bp_data", 32'(bus.m_data), 32'h10);
    chk("bp_valid", 32'(bus.m_valid), 32'd1);
    bus.m_ready = 1'b1;
    wait_drain(40);
    check_got(gb, 8'h10, 8);
    chk("bp_cnt", 32'(word_cnt), 32'd8);

    // Empty pulse of 3 cycles mid-stream.
    start_test(8'h30, 1'b1);
    gb = got_q.size();
    repeat (3) next_cycle();
    gap = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge rdclk);
      chk("gap_pop", 32'(bus.fifo_pop), 32'd0);
      if (k == 2) chk("gap_valid", 32'(bus.m_valid), 32'd0);
      next_cycle();
    end
    gap = 1'b0;
    @(negedge rdclk);
    chk("gap_resume_pop", 32'(bus.fifo_pop), 32'd1);
    wait_drain(40);
    check_got(gb, 8'h30, 8);
    chk("gap_cnt", 32'(word_cnt), 32'd8);

    // Enable drop right after the pop of 0x44.
    start_test(8'h40, 1'b1);
    gb = got_q.size();
    repeat (4) next_cycle();
    @(negedge rdclk);
    chk("en_pop_c4", 32'(bus.fifo_pop), 32'd1);
    next_cycle();
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge rdclk);
      chk("en_off_pop", 32'(bus.fifo_pop), 32'd0);
      next_cycle();
    end
    wait_drain(20);
    chk("en_off_cnt", 32'(word_cnt), 32'd5);
    chk("en_off_pops", 32'(pops_total), 32'd5);
    check_got(gb, 8'h40, 5);
    en = 1'b1;
    wait_drain(40);
    check_got(gb, 8'h40, 8);
    chk("en_on_cnt", 32'(word_cnt), 32'd8);

    // Reset mid-frame with one word buffered and one in flight.
    start_test(8'h50, 1'b1);
    repeat (4) next_cycle();
    chk("mid_cnt_pre", 32'(word_cnt), 32'd2);
    chk("mid_state_pre", 32'(dbg_state), 32'd1);
    chk("mid_data_pre", 32'(bus.m_data), 32'h52);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    rd_rst = 1'b0;
    #1;
    chk("mid_state", 32'(dbg_state), 32'd0);
    chk("mid_cnt", 32'(word_cnt), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_valid", 32'(bus.m_valid), 32'd0);
    chk("mid_pop", 32'(bus.fifo_pop), 32'd0);
    next_cycle();
    next_cycle();
    rd_rst = 1'b1;
    gb = got_q.size();
    wait_drain(40);
    check_got(gb, 8'h54, 4);
    chk("mid_cnt_post", 32'(word_cnt), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule
